// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding and hazard controller: tracks in-flight destinations in a shadow
// pipeline, stalls D on unresolvable RAW or mult/div hazards, and registers E-stage mux selects.
module fwd_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic [1:0] d_md_op,
    output logic       stall,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       md_busy
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W = $clog2(MAX_LAT + 1);
    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10,
        MD_HILO = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        SEL_PIPE = 2'b00,
        SEL_M    = 2'b01,
        SEL_W    = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
    } stage_t;

    // The shadow pipeline ends at M: a producer already in W is only ever reached through
    // the W-stage mux input, which is selected while that producer is still in M.
    stage_t            e_q, e_d;
    stage_t            m_q, m_d;
    md_op_e            e_md_q, e_md_d;
    logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
    fwd_sel_e          fwd_rs_q, fwd_rs_d;
    fwd_sel_e          fwd_rt_q, fwd_rt_d;

    md_op_e d_md;
    logic   raw_rs, raw_rt, md_hazard, e_is_md, issue;

    function automatic logic raw_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input stage_t e, input stage_t m);
        return (src != 5'd0) && (tuse != TUSE_NONE) &&
               (((e.wa == src) && (e.tnew > tuse)) || ((m.wa == src) && (m.tnew > tuse)));
    endfunction

    // Nearest producer wins; an E producer that is not ready yields no select (D stalls).
    function automatic fwd_sel_e fwd_select(input logic [4:0] src, input logic [1:0] tuse,
                                            input stage_t e, input stage_t m);
        if ((src == 5'd0) || (tuse == TUSE_NONE)) return SEL_PIPE;
        if (e.wa == src) return (e.tnew <= 2'd1) ? SEL_M : SEL_PIPE;
        if (m.wa == src) return SEL_W;
        return SEL_PIPE;
    endfunction

    assign d_md = md_op_e'(d_md_op);

    always_comb begin
        raw_rs    = d_valid && raw_hazard(d_rs, d_tuse_rs, e_q, m_q);
        raw_rt    = d_valid && raw_hazard(d_rt, d_tuse_rt, e_q, m_q);
        e_is_md   = (e_md_q == MD_MULT) || (e_md_q == MD_DIV);
        md_hazard = d_valid && (d_md != MD_NONE) && ((md_cnt_q != '0) || e_is_md);
        stall     = raw_rs || raw_rt || md_hazard;
        issue     = d_valid && !stall;
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can infer a latch.
        e_d      = '0;
        e_md_d   = MD_NONE;
        fwd_rs_d = SEL_PIPE;
        fwd_rt_d = SEL_PIPE;

        if (issue) begin
            e_d.wa   = d_wa;
            e_d.tnew = d_tnew;
            if ((d_md == MD_MULT) || (d_md == MD_DIV)) e_md_d = d_md;
            fwd_rs_d = fwd_select(d_rs, d_tuse_rs, e_q, m_q);
            fwd_rt_d = fwd_select(d_rt, d_tuse_rt, e_q, m_q);
        end

        m_d.wa   = e_q.wa;
        m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;

        unique case (e_md_q)
            MD_MULT: md_cnt_d = CNT_W'(MUL_LAT);
            MD_DIV:  md_cnt_d = CNT_W'(DIV_LAT);
            default: md_cnt_d = (md_cnt_q != '0) ? md_cnt_q - CNT_W'(1) : md_cnt_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q      <= '0;
            m_q      <= '0;
            e_md_q   <= MD_NONE;
            md_cnt_q <= '0;
            fwd_rs_q <= SEL_PIPE;
            fwd_rt_q <= SEL_PIPE;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            e_md_q   <= e_md_d;
            md_cnt_q <= md_cnt_d;
            fwd_rs_q <= fwd_rs_d;
            fwd_rt_q <= fwd_rt_d;
        end
    end

    assign fwd_rs_e = fwd_rs_q;
    assign fwd_rt_e = fwd_rt_q;
    assign md_busy  = (md_cnt_q != '0);

endmodule
